// File: rtl/instr_pkg.sv
// Purpose: RV32I op enumeration, opcode/funct constants and format helpers shared by encoder and decoder.
// Latency: none, declarations only.
// Backpressure: not applicable.
package instr_pkg;

    // Request operation codes; values 12..15 are illegal and deliberately not named.
    typedef enum logic [3:0] {
        OPC_ADD   = 4'd0,
        OPC_SUB   = 4'd1,
        OPC_AND   = 4'd2,
        OPC_OR    = 4'd3,
        OPC_SLT   = 4'd4,
        OPC_LW    = 4'd5,
        OPC_SW    = 4'd6,
        OPC_ADDI  = 4'd7,
        OPC_AUIPC = 4'd8,
        OPC_JAL   = 4'd9,
        OPC_BEQ   = 4'd10,
        OPC_BLT   = 4'd11
    } in_op_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BLT     = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // R-type layout: f7|rs2|rs1|f3|rd|opcode.
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_RTYPE};
    endfunction

    // I-type layout: imm[11:0]|rs1|f3|rd|opcode.
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Purpose: map one request (op, registers, immediate) to its 32-bit RV32I word plus an illegal flag.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module instr_field_pack
    import instr_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Select the format; jump/branch offsets must be even, anything else unknown is illegal.
    always_comb begin
        word_o    = 32'd0;
        illegal_o = 1'b0;
        case (op_i)
            OPC_ADD:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_ADD_SUB, rd_i);
            OPC_SUB:   word_o = enc_r(F7_SUB,  rs2_i, rs1_i, F3_ADD_SUB, rd_i);
            OPC_AND:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_AND,     rd_i);
            OPC_OR:    word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_OR,      rd_i);
            OPC_SLT:   word_o = enc_r(F7_BASE, rs2_i, rs1_i, F3_SLT,     rd_i);
            OPC_LW:    word_o = enc_i(imm_i[11:0], rs1_i, F3_LW,   rd_i, OP_LOAD);
            OPC_ADDI:  word_o = enc_i(imm_i[11:0], rs1_i, F3_ADDI, rd_i, OP_IMM);
            OPC_SW:    word_o = {imm_i[11:5], rs2_i, rs1_i, F3_SW, imm_i[4:0], OP_STORE};
            OPC_AUIPC: word_o = {imm_i[31:12], rd_i, OP_AUIPC};
            OPC_JAL: begin
                word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
                illegal_o = imm_i[0];
            end
            OPC_BEQ: begin
                word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                             imm_i[4:1], imm_i[11], OP_BRANCH};
                illegal_o = imm_i[0];
            end
            OPC_BLT: begin
                word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BLT,
                             imm_i[4:1], imm_i[11], OP_BRANCH};
                illegal_o = imm_i[0];
            end
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Purpose: accept field-level requests, encode them and write consecutive instruction-memory words.
// Latency: 1 cycle from accepted request to imem write.
// Backpressure: in_ready low during reset/start or once DEPTH words are written; memory never stalls.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              full_q;
    logic              err_q;

    logic [31:0]       word;
    logic              illegal;
    logic              xfer;
    logic [ADDR_W:0]   count_inc;

    instr_field_pack u_pack (
        .op_i      (in_op),
        .rd_i      (in_rd),
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .imm_i     (in_imm),
        .word_o    (word),
        .illegal_o (illegal)
    );

    assign in_ready  = !reset && !start && !full_q;
    assign xfer      = in_valid && in_ready;
    assign count_inc = count_q + 1'b1;

    // Output register, write counter and sticky flags; start clears a program but not an in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= BASE_C;
            wdata_q <= 32'd0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (start) begin
                addr_q  <= BASE_C;
                count_q <= '0;
                full_q  <= 1'b0;
                err_q   <= 1'b0;
            end else if (xfer) begin
                if (illegal) begin
                    err_q <= 1'b1;
                end else begin
                    we_q    <= 1'b1;
                    addr_q  <= BASE_C + count_q[ADDR_W-1:0];
                    wdata_q <= word;
                    count_q <= count_inc;
                    full_q  <= (count_inc == DEPTH_C);
                end
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = full_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Purpose: directed plus randomized checking of instr_encoder against a behavioural program-loader model.
// Latency: expects writes one cycle after each accepted request.
// Backpressure: expects in_ready to fall with full, reset or start.
module tb_instr_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int BASE   = 0;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [31:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full, err;

    int errors = 0;
    int checks = 0;

    // Model state: what a program loader should look like after each edge.
    int      m_count = 0;
    bit      m_err   = 0;
    bit      m_we    = 0;
    int      m_addr  = BASE;
    longint  m_wdata = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoding built by placing each field at its bit position with arithmetic.
    function automatic longint ref_word(input int op, input int rd, input int rs1, input int rs2,
                                        input longint imm, output bit bad);
        longint w;
        longint f3;
        bad = 0;
        w   = 0;
        case (op)
            0, 1, 2, 3, 4: begin
                f3 = (op == 2) ? 7 : (op == 3) ? 6 : (op == 4) ? 2 : 0;
                w  = ((op == 1) ? 32 : 0) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
                     + f3 * (1 << 12) + rd * (1 << 7) + 'h33;
            end
            5: w = (imm % 4096 + 4096) % 4096 * (1 << 20) + rs1 * (1 << 15) + 2 * (1 << 12)
                   + rd * (1 << 7) + 'h03;
            7: w = (imm % 4096 + 4096) % 4096 * (1 << 20) + rs1 * (1 << 15) + rd * (1 << 7) + 'h13;
            6: w = ((imm >> 5) & 'h7F) * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15)
                   + 2 * (1 << 12) + (imm & 'h1F) * (1 << 7) + 'h23;
            8: w = ((imm >> 12) & 'hFFFFF) * (1 << 12) + rd * (1 << 7) + 'h17;
            9: begin
                bad = imm[0];
                w = ((imm >> 20) & 1) * (longint'(1) << 31) + ((imm >> 1) & 'h3FF) * (1 << 21)
                    + ((imm >> 11) & 1) * (1 << 20) + ((imm >> 12) & 'hFF) * (1 << 12)
                    + rd * (1 << 7) + 'h6F;
            end
            10, 11: begin
                bad = imm[0];
                w = ((imm >> 12) & 1) * (longint'(1) << 31) + ((imm >> 5) & 'h3F) * (1 << 25)
                    + rs2 * (1 << 20) + rs1 * (1 << 15) + ((op == 11) ? 4 : 0) * (1 << 12)
                    + ((imm >> 1) & 'hF) * (1 << 8) + ((imm >> 11) & 1) * (1 << 7) + 'h63;
            end
            default: bad = 1;
        endcase
        return w;
    endfunction

    // One clock of stimulus: drive, check readiness, advance model, check outputs.
    task automatic step(input bit rst, input bit st, input bit v, input int op, input int rd,
                        input int rs1, input int rs2, input longint imm);
        bit     rdy, bad;
        longint w;
        @(negedge clk);
        reset = rst; start = st; in_valid = v;
        in_op = 4'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 32'(imm);
        #1;
        rdy = !rst && !st && (m_count != DEPTH);
        chk("in_ready", longint'(in_ready), longint'(rdy));
        w = ref_word(op, rd, rs1, rs2, imm & 'hFFFFFFFF, bad);
        @(posedge clk);
        m_we = 0;
        if (rst) begin
            m_count = 0; m_err = 0; m_addr = BASE; m_wdata = 0;
        end else if (st) begin
            m_count = 0; m_err = 0; m_addr = BASE;
        end else if (v && rdy) begin
            if (bad) m_err = 1;
            else begin
                m_we = 1; m_addr = BASE + m_count; m_wdata = w; m_count++;
            end
        end
        #1;
        chk("imem_we", longint'(imem_we), longint'(m_we));
        chk("imem_addr", longint'(imem_addr), longint'(m_addr));
        chk("imem_wdata", longint'(imem_wdata), m_wdata);
        chk("count", longint'(count), longint'(m_count));
        chk("full", longint'(full), longint'(m_count == DEPTH));
        chk("err", longint'(err), longint'(m_err));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; start = 0; in_valid = 0; in_op = 0;
        in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_ready", longint'(in_ready), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_count", longint'(count), 0);
        idle();

        // ADD x3,x1,x2
        step(0, 0, 1, 0, 3, 1, 2, 0);
        chk("add_word", longint'(imem_wdata), 'h002081B3);
        chk("add_count", longint'(count), 1);
        idle();

        // Back-to-back ADDI / LW / SW at addresses 0..2
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7, 1, 0, 0, 5);
        chk("addi_word", longint'(imem_wdata), 'h00500093);
        chk("addi_addr", longint'(imem_addr), 0);
        step(0, 0, 1, 5, 2, 1, 0, 8);
        chk("lw_word", longint'(imem_wdata), 'h0080A103);
        chk("lw_addr", longint'(imem_addr), 1);
        step(0, 0, 1, 6, 0, 1, 2, 4);
        chk("sw_word", longint'(imem_wdata), 'h0020A223);
        chk("sw_addr", longint'(imem_addr), 2);

        // BEQ x1,x2,-4 then JAL x1,8
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 10, 0, 1, 2, -4);
        chk("beq_word", longint'(imem_wdata), 'hFE208EE3);
        step(0, 0, 1, 9, 1, 0, 0, 8);
        chk("jal_word", longint'(imem_wdata), 'h008000EF);

        // Illegal op and misaligned branch, then a legal ADDI
        step(0, 0, 1, 13, 1, 1, 1, 0);
        chk("illegal_we", longint'(imem_we), 0);
        step(0, 0, 1, 11, 0, 1, 2, 3);
        chk("misalign_we", longint'(imem_we), 0);
        chk("misalign_err", longint'(err), 1);
        chk("misalign_count", longint'(count), 2);
        step(0, 0, 1, 7, 4, 4, 0, 12);
        chk("after_err_addr", longint'(imem_addr), 2);
        chk("after_err_err", longint'(err), 1);

        // Fill: six requests with valid held high, only DEPTH land
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 7, i + 1, 0, 0, i);
        chk("fill_full", longint'(full), 1);
        chk("fill_count", longint'(count), DEPTH);
        chk("fill_ready", longint'(in_ready), 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("restart_count", longint'(count), 0);
        step(0, 0, 1, 0, 5, 6, 7, 0);
        chk("restart_addr", longint'(imem_addr), BASE);

        // Start right after a transfer: in-flight word keeps its address
        step(0, 0, 1, 2, 8, 9, 10, 0);
        chk("inflight_addr", longint'(imem_addr), 1);
        step(0, 1, 1, 3, 8, 9, 10, 0);
        chk("start_no_write", longint'(imem_we), 0);
        step(0, 0, 1, 4, 1, 2, 3, 0);
        chk("post_start_addr", longint'(imem_addr), BASE);

        // Randomized traffic with occasional start and reset
        for (int i = 0; i < 400; i++) begin
            int     r;
            longint imm;
            r   = $urandom_range(0, 99);
            imm = longint'($urandom);
            step(r == 0, (r >= 1 && r <= 6), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), imm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
